// File: rtl/key_conditioner.sv
// Board push-button front end: per-key synchronizer, debounce FSM and
// registered one-cycle press/release strobes for the game core.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                CLOCK_50,
  input  logic                reset_N,
  input  logic [NUM_KEYS-1:0] KEY_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Bit 1 of the state is the debounced level, so key_level comes straight off a flop.
  localparam logic [1:0] ST_UP     = 2'b00;
  localparam logic [1:0] ST_CHK_DN = 2'b01;
  localparam logic [1:0] ST_DOWN   = 2'b10;
  localparam logic [1:0] ST_CHK_UP = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   press_q, press_d;
    logic                   rls_q, rls_d;
    logic                   s, done;

    always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], KEY_raw[g]};
      s       = ~sync_q[SYNC_STAGES-1];
      // >= rather than == keeps DEBOUNCE_CYCLES=1 accepting on the first check cycle.
      done    = (cnt_q >= CNT_LAST);
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rls_d   = 1'b0;
      case (state_q)
        ST_UP: begin
          if (s) begin
            state_d = ST_CHK_DN;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        ST_CHK_DN: begin
          if (!s) begin
            state_d = ST_UP;
            cnt_d   = '0;
          end else if (done) begin
            state_d = ST_DOWN;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DOWN: begin
          if (!s) begin
            state_d = ST_CHK_UP;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        ST_CHK_UP: begin
          if (s) begin
            state_d = ST_DOWN;
            cnt_d   = '0;
          end else if (done) begin
            state_d = ST_UP;
            cnt_d   = '0;
            rls_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_UP;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_N) begin
      if (!reset_N) begin
        sync_q  <= '1;
        state_q <= ST_UP;
        cnt_q   <= '0;
        press_q <= 1'b0;
        rls_q   <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
        rls_q   <= rls_d;
      end
    end

    assign key_level[g]   = state_q[1];
    assign key_press[g]   = press_q;
    assign key_release[g] = rls_q;
  end

endmodule
